// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared constants and types for the machine-mode trap sequencer.
//   - CSR addresses written or read by the trap sequence
//   - mcause codes for ECALL, EBREAK and the machine timer interrupt
//   - SYSTEM instruction encodings recognised in ID
//   - mstatus bit positions and the sequencer state encoding
package trap_ctrl_pkg;

   localparam logic [11:0] CsrMstatus = 12'h300;
   localparam logic [11:0] CsrMtvec   = 12'h305;
   localparam logic [11:0] CsrMepc    = 12'h341;
   localparam logic [11:0] CsrMcause  = 12'h342;

   localparam logic [31:0] CauseEcall  = 32'h0000_000B;
   localparam logic [31:0] CauseEbreak = 32'h0000_0003;
   localparam logic [31:0] CauseTimer  = 32'h8000_0007;

   localparam logic [31:0] InstEcall  = 32'h0000_0073;
   localparam logic [31:0] InstEbreak = 32'h0010_0073;
   localparam logic [31:0] InstMret   = 32'h3020_0073;

   localparam int unsigned MieBit  = 3;
   localparam int unsigned MpieBit = 7;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StMepc    = 3'd1,
      StMcause  = 3'd2,
      StMstatus = 3'd3,
      StMret    = 3'd4,
      StJump    = 3'd5
   } trap_state_e;

endpackage

// File: rtl/trap_ctrl_decode.sv
// trap_ctrl_decode: combinational trap event detection with fixed priority
// sync (ECALL/EBREAK) > mret > async (enabled timer interrupt).
// Ports:
//   en_i           - detection enable (IDLE, no stall, not in reset)
//   inst_i         - instruction in ID
//   irq_timer_i    - level-sensitive timer interrupt
//   mie_i          - mstatus.MIE
//   event_sync_o   - ECALL or EBREAK detected
//   event_mret_o   - MRET detected
//   event_async_o  - timer interrupt taken
//   cause_o        - mcause value for sync/async events (0 otherwise)
module trap_ctrl_decode
   import trap_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] inst_i,
   input  logic                  irq_timer_i,
   input  logic                  mie_i,
   output logic                  event_sync_o,
   output logic                  event_mret_o,
   output logic                  event_async_o,
   output logic [DATA_WIDTH-1:0] cause_o
);

   logic is_ecall, is_ebreak, is_mret;

   always_comb begin
      is_ecall      = (inst_i == DATA_WIDTH'(InstEcall));
      is_ebreak     = (inst_i == DATA_WIDTH'(InstEbreak));
      is_mret       = (inst_i == DATA_WIDTH'(InstMret));
      event_sync_o  = en_i & (is_ecall | is_ebreak);
      event_mret_o  = en_i & is_mret & ~event_sync_o;
      event_async_o = en_i & irq_timer_i & mie_i & ~is_ecall & ~is_ebreak & ~is_mret;
      cause_o       = '0;
      if (event_sync_o) begin
         cause_o = is_ecall ? DATA_WIDTH'(CauseEcall) : DATA_WIDTH'(CauseEbreak);
      end else if (event_async_o) begin
         cause_o = DATA_WIDTH'(CauseTimer);
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer beside the ID stage.
// On ECALL/EBREAK/enabled timer IRQ it holds the pipeline, writes mepc, mcause and
// mstatus (one per cycle), then redirects fetch to mtvec. On MRET it restores
// mstatus and redirects fetch to mepc.
// Ports:
//   clk_i, rst_n_i              - clock, asynchronous active-low reset
//   inst_i, inst_addr_i         - instruction in ID and its address
//   stallreq_i                  - load-hazard stall from ID (suppresses detection)
//   jump_flag_i, jump_addr_i    - EX redirect, used as epc for interrupts
//   irq_timer_i                 - timer interrupt level
//   csr_mtvec_i/mepc_i/mstatus_i- current CSR values
//   csr_we_o/waddr_o/wdata_o    - CSR file write port
//   hold_o                      - pipeline freeze
//   int_assert_o, int_addr_o    - one-cycle fetch redirect and target
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [DATA_WIDTH-1:0] inst_i,
   input  logic [ADDR_WIDTH-1:0] inst_addr_i,
   input  logic                  stallreq_i,
   input  logic                  jump_flag_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i,
   input  logic                  irq_timer_i,
   input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
   input  logic [DATA_WIDTH-1:0] csr_mepc_i,
   input  logic [DATA_WIDTH-1:0] csr_mstatus_i,
   output logic                  csr_we_o,
   output logic [11:0]           csr_waddr_o,
   output logic [DATA_WIDTH-1:0] csr_wdata_o,
   output logic                  hold_o,
   output logic                  int_assert_o,
   output logic [ADDR_WIDTH-1:0] int_addr_o
);

   trap_state_e           state_q;
   logic [DATA_WIDTH-1:0] cause_q;
   logic [ADDR_WIDTH-1:0] epc_q;
   logic [DATA_WIDTH-1:0] target_q;
   logic                  csr_we_q;
   logic [11:0]           csr_waddr_q;
   logic [DATA_WIDTH-1:0] csr_wdata_q;
   logic                  int_assert_q;
   logic [ADDR_WIDTH-1:0] int_addr_q;

   logic                  detect_en;
   logic                  event_sync, event_mret, event_async;
   logic [DATA_WIDTH-1:0] event_cause;
   logic [ADDR_WIDTH-1:0] trap_epc;
   logic [DATA_WIDTH-1:0] trap_mstatus, mret_mstatus;

   // rst_n_i gates detection so hold_o also reads 0 while reset is asserted.
   assign detect_en = (state_q == StIdle) & ~stallreq_i & rst_n_i;

   trap_ctrl_decode #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_decode (
      .en_i          (detect_en),
      .inst_i        (inst_i),
      .irq_timer_i   (irq_timer_i),
      .mie_i         (csr_mstatus_i[MieBit]),
      .event_sync_o  (event_sync),
      .event_mret_o  (event_mret),
      .event_async_o (event_async),
      .cause_o       (event_cause)
   );

   always_comb begin
      // An interrupt resumes at the instruction EX is jumping to, if any.
      trap_epc = (event_async && jump_flag_i) ? jump_addr_i : inst_addr_i;
      trap_mstatus          = csr_mstatus_i;
      trap_mstatus[MpieBit] = csr_mstatus_i[MieBit];
      trap_mstatus[MieBit]  = 1'b0;
      mret_mstatus          = csr_mstatus_i;
      mret_mstatus[MieBit]  = csr_mstatus_i[MpieBit];
      mret_mstatus[MpieBit] = 1'b1;
   end

   // Outputs are registered with the state they belong to: each transition loads
   // the write/redirect values that the entered state presents.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= StIdle;
         cause_q      <= '0;
         epc_q        <= '0;
         target_q     <= '0;
         csr_we_q     <= 1'b0;
         csr_waddr_q  <= '0;
         csr_wdata_q  <= '0;
         int_assert_q <= 1'b0;
         int_addr_q   <= '0;
      end else begin
         csr_we_q     <= 1'b0;
         csr_waddr_q  <= '0;
         csr_wdata_q  <= '0;
         int_assert_q <= 1'b0;
         int_addr_q   <= '0;
         unique case (state_q)
            StIdle: begin
               if (event_sync || event_async) begin
                  cause_q     <= event_cause;
                  epc_q       <= trap_epc;
                  target_q    <= csr_mtvec_i;
                  state_q     <= StMepc;
                  csr_we_q    <= 1'b1;
                  csr_waddr_q <= CsrMepc;
                  csr_wdata_q <= DATA_WIDTH'(trap_epc);
               end else if (event_mret) begin
                  state_q     <= StMret;
                  csr_we_q    <= 1'b1;
                  csr_waddr_q <= CsrMstatus;
                  csr_wdata_q <= mret_mstatus;
               end
            end
            StMepc: begin
               state_q     <= StMcause;
               csr_we_q    <= 1'b1;
               csr_waddr_q <= CsrMcause;
               csr_wdata_q <= cause_q;
            end
            StMcause: begin
               state_q     <= StMstatus;
               csr_we_q    <= 1'b1;
               csr_waddr_q <= CsrMstatus;
               csr_wdata_q <= trap_mstatus;
            end
            StMstatus: begin
               state_q      <= StJump;
               int_assert_q <= 1'b1;
               int_addr_q   <= ADDR_WIDTH'(target_q);
            end
            StMret: begin
               // mepc is sampled while mstatus is being written; no forwarding assumed.
               target_q     <= csr_mepc_i;
               state_q      <= StJump;
               int_assert_q <= 1'b1;
               int_addr_q   <= ADDR_WIDTH'(csr_mepc_i);
            end
            StJump: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign hold_o       = (state_q != StIdle) | event_sync | event_mret | event_async;
   assign csr_we_o     = csr_we_q;
   assign csr_waddr_o  = csr_waddr_q;
   assign csr_wdata_o  = csr_wdata_q;
   assign int_assert_o = int_assert_q;
   assign int_addr_o   = int_addr_q;

   // Only read as part of the CSR address map; mtvec arrives on its own port.
   logic [11:0] unused_mtvec_addr;
   assign unused_mtvec_addr = CsrMtvec;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-table reference model derived from the trap rules.
module tb_trap_ctrl;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [31:0] inst_i, inst_addr_i, jump_addr_i, mtvec, mepc, mstatus;
   logic        stallreq_i, jump_flag_i, irq_timer_i;
   logic        csr_we_o, hold_o, int_assert_o;
   logic [11:0] csr_waddr_o;
   logic [31:0] csr_wdata_o, int_addr_o;

   int nerr = 0;
   int nchk = 0;

   // Per-cycle capture buffers.
   logic        h[8], we[8], ia[8];
   logic [11:0] wa[8];
   logic [31:0] wd[8], iad[8];

   always #5 clk_i = ~clk_i;

   trap_ctrl #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32)
   ) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .inst_i        (inst_i),
      .inst_addr_i   (inst_addr_i),
      .stallreq_i    (stallreq_i),
      .jump_flag_i   (jump_flag_i),
      .jump_addr_i   (jump_addr_i),
      .irq_timer_i   (irq_timer_i),
      .csr_mtvec_i   (mtvec),
      .csr_mepc_i    (mepc),
      .csr_mstatus_i (mstatus),
      .csr_we_o      (csr_we_o),
      .csr_waddr_o   (csr_waddr_o),
      .csr_wdata_o   (csr_wdata_o),
      .hold_o        (hold_o),
      .int_assert_o  (int_assert_o),
      .int_addr_o    (int_addr_o)
   );

   // Sample n cycles starting now (inputs already driven for cycle 0). A redirect
   // flushes ID to a NOP, like the real pipeline would; drop_irq also lowers the IRQ.
   task automatic cap(input int n, input bit drop_irq);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk_i);
         #1;
         h[i] = hold_o; we[i] = csr_we_o; wa[i] = csr_waddr_o; wd[i] = csr_wdata_o;
         ia[i] = int_assert_o; iad[i] = int_addr_o;
         if (int_assert_o) begin
            inst_i = NOP;
            jump_flag_i = 1'b0;
            if (drop_irq) irq_timer_i = 1'b0;
         end
      end
   endtask

   task automatic set_idle_inputs();
      inst_i = NOP; inst_addr_i = 32'h0; stallreq_i = 1'b0; jump_flag_i = 1'b0;
      jump_addr_i = 32'h0; irq_timer_i = 1'b0; mtvec = 32'h0; mepc = 32'h0; mstatus = 32'h0;
   endtask

   task automatic test_reset();
      set_idle_inputs();
      rst_n_i = 1'b0;
      #12;
      nchk++; if ({csr_we_o, csr_waddr_o, csr_wdata_o} !== 45'h0) begin
         nerr++; $display("FAIL reset_csr: got %h expected 0", {csr_we_o, csr_waddr_o, csr_wdata_o});
      end
      nchk++; if ({hold_o, int_assert_o, int_addr_o} !== 34'h0) begin
         nerr++; $display("FAIL reset_ctl: got %h expected 0", {hold_o, int_assert_o, int_addr_o});
      end
      @(negedge clk_i); rst_n_i = 1'b1;
      @(negedge clk_i); #1;
      nchk++; if ({hold_o, csr_we_o, int_assert_o} !== 3'b000) begin
         nerr++; $display("FAIL reset_release: got %b expected 000", {hold_o, csr_we_o, int_assert_o});
      end
   endtask

   task automatic test_ecall();
      @(negedge clk_i);
      inst_i = ECALL; inst_addr_i = 32'h10; mtvec = 32'h100; mstatus = 32'h8;
      cap(6, 1'b1);
      for (int c = 0; c < 6; c++) begin
         nchk++; if (h[c] !== (c <= 4)) begin
            nerr++; $display("FAIL ecall_hold c%0d: got %b expected %b", c, h[c], c <= 4);
         end
      end
      nchk++; if ({we[0], we[1], wa[1], wd[1]} !== {1'b0, 1'b1, 12'h341, 32'h10}) begin
         nerr++; $display("FAIL ecall_mepc: got %b %h %h expected 1 341 10", we[1], wa[1], wd[1]);
      end
      nchk++; if ({we[2], wa[2], wd[2]} !== {1'b1, 12'h342, 32'hB}) begin
         nerr++; $display("FAIL ecall_mcause: got %b %h %h expected 1 342 b", we[2], wa[2], wd[2]);
      end
      nchk++; if ({we[3], wa[3], wd[3]} !== {1'b1, 12'h300, 32'h80}) begin
         nerr++; $display("FAIL ecall_mstatus: got %b %h %h expected 1 300 80", we[3], wa[3], wd[3]);
      end
      nchk++; if ({we[4], wa[4], wd[4], ia[3], ia[4], iad[4], ia[5], iad[5]} !==
                  {1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0}) begin
         nerr++; $display("FAIL ecall_jump: got ia=%b%b%b addr=%h we4=%b expected 010 100 0",
                          ia[3], ia[4], ia[5], iad[4], we[4]);
      end
   endtask

   task automatic test_timer();
      @(negedge clk_i);
      inst_i = NOP; inst_addr_i = 32'h24; jump_flag_i = 1'b1; jump_addr_i = 32'h40;
      irq_timer_i = 1'b1; mstatus = 32'h8; mtvec = 32'h200;
      cap(6, 1'b1);
      nchk++; if ({h[0], wa[1], wd[1], wa[2], wd[2], wd[3], ia[4], iad[4]} !==
                  {1'b1, 12'h341, 32'h40, 12'h342, 32'h8000_0007, 32'h80, 1'b1, 32'h200}) begin
         nerr++; $display("FAIL timer_entry: got mepc=%h mcause=%h mst=%h jump=%b/%h",
                          wd[1], wd[2], wd[3], ia[4], iad[4]);
      end
      @(negedge clk_i);
      inst_addr_i = 32'h24; jump_flag_i = 1'b1; jump_addr_i = 32'h40;
      irq_timer_i = 1'b1; mstatus = 32'h0;
      cap(5, 1'b1);
      for (int c = 0; c < 5; c++) begin
         nchk++; if ({h[c], we[c], ia[c]} !== 3'b000) begin
            nerr++; $display("FAIL timer_masked c%0d: got %b expected 000", c, {h[c], we[c], ia[c]});
         end
      end
      irq_timer_i = 1'b0; jump_flag_i = 1'b0;
   endtask

   task automatic test_mret();
      @(negedge clk_i);
      inst_i = MRET; inst_addr_i = 32'h60; mepc = 32'h14; mstatus = 32'h80;
      cap(5, 1'b1);
      nchk++; if ({h[0], h[1], h[2], h[3]} !== 4'b1110) begin
         nerr++; $display("FAIL mret_hold: got %b expected 1110", {h[0], h[1], h[2], h[3]});
      end
      nchk++; if ({we[0], we[1], wa[1], wd[1], we[2]} !== {1'b0, 1'b1, 12'h300, 32'h88, 1'b0}) begin
         nerr++; $display("FAIL mret_mstatus: got %b %h %h expected 1 300 88", we[1], wa[1], wd[1]);
      end
      nchk++; if ({ia[1], ia[2], iad[2], ia[3]} !== {1'b0, 1'b1, 32'h14, 1'b0}) begin
         nerr++; $display("FAIL mret_jump: got %b%b%b %h expected 010 14", ia[1], ia[2], ia[3], iad[2]);
      end
   endtask

   task automatic test_ecall_with_irq();
      @(negedge clk_i);
      inst_i = ECALL; inst_addr_i = 32'h50; irq_timer_i = 1'b1; mstatus = 32'h8; mtvec = 32'h100;
      cap(7, 1'b0);
      nchk++; if ({wd[1], wd[2], ia[4]} !== {32'h50, 32'hB, 1'b1}) begin
         nerr++; $display("FAIL prio_cause: got mepc=%h mcause=%h expected 50 b", wd[1], wd[2]);
      end
      nchk++; if ({h[5], we[6], wa[6], wd[6]} !== {1'b1, 1'b1, 12'h341, 32'h50}) begin
         nerr++; $display("FAIL irq_retake: got hold=%b we=%b %h %h expected 1 1 341 50",
                          h[5], we[6], wa[6], wd[6]);
      end
      @(negedge clk_i);
      cap(5, 1'b1);
      nchk++; if ({wa[0], wd[0], ia[2], h[4]} !== {12'h342, 32'h8000_0007, 1'b1, 1'b0}) begin
         nerr++; $display("FAIL irq_retake_cause: got %h %h ia=%b hold=%b expected 342 80000007 1 0",
                          wa[0], wd[0], ia[2], h[4]);
      end
   endtask

   task automatic test_stall();
      @(negedge clk_i);
      inst_i = ECALL; inst_addr_i = 32'h30; stallreq_i = 1'b1; mstatus = 32'h0; mtvec = 32'h180;
      for (int c = 0; c < 2; c++) begin
         if (c > 0) @(negedge clk_i);
         #1;
         nchk++; if ({hold_o, csr_we_o} !== 2'b00) begin
            nerr++; $display("FAIL stall_c%0d: got %b expected 00", c, {hold_o, csr_we_o});
         end
      end
      @(negedge clk_i);
      stallreq_i = 1'b0;
      cap(6, 1'b1);
      nchk++; if ({h[0], we[1], wd[1], ia[4], iad[4], h[5]} !== {1'b1, 1'b1, 32'h30, 1'b1, 32'h180, 1'b0}) begin
         nerr++; $display("FAIL stall_release: got hold=%b mepc=%h jump=%h expected 1 30 180", h[0], wd[1], iad[4]);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk_i);
      inst_i = ECALL; inst_addr_i = 32'h70; mstatus = 32'h8; mtvec = 32'h100;
      cap(3, 1'b1);
      nchk++; if ({we[2], wa[2]} !== {1'b1, 12'h342}) begin
         nerr++; $display("FAIL rstmid_precond: got %b %h expected 1 342", we[2], wa[2]);
      end
      rst_n_i = 1'b0;
      #1;
      nchk++; if ({hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o} !== 79'h0) begin
         nerr++; $display("FAIL rstmid_outputs: got %h expected 0",
                          {hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o});
      end
      inst_i = NOP;
      @(negedge clk_i); rst_n_i = 1'b1;
      cap(5, 1'b1);
      for (int c = 0; c < 5; c++) begin
         nchk++; if ({h[c], we[c], ia[c]} !== 3'b000) begin
            nerr++; $display("FAIL rstmid_after c%0d: got %b expected 000", c, {h[c], we[c], ia[c]});
         end
      end
   endtask

   task automatic test_random();
      logic [78:0] act, exp;
      logic        sync, mr, as;
      logic [31:0] cause, epc, mst_trap, mst_mret;
      for (int it = 0; it < 40; it++) begin
         @(negedge clk_i);
         case ($urandom_range(0, 5))
            0: inst_i = ECALL;
            1: inst_i = EBREAK;
            2: inst_i = MRET;
            3, 4: inst_i = NOP;
            default: inst_i = $urandom;
         endcase
         inst_addr_i = $urandom & 32'hFFFF_FFFC;
         jump_addr_i = $urandom & 32'hFFFF_FFFC;
         jump_flag_i = $urandom_range(0, 1);
         irq_timer_i = $urandom_range(0, 1);
         mstatus = $urandom; mtvec = $urandom; mepc = $urandom;
         stallreq_i = 1'b0;
         // Reference model: event, cause, epc and new mstatus from the trap rules.
         sync = (inst_i == ECALL) || (inst_i == EBREAK);
         mr = (inst_i == MRET);
         as = irq_timer_i && mstatus[3] && !sync && !mr;
         cause = (inst_i == ECALL) ? 32'hB : (inst_i == EBREAK) ? 32'h3 : 32'h8000_0007;
         epc = (as && jump_flag_i) ? jump_addr_i : inst_addr_i;
         mst_trap = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0);
         mst_mret = (mstatus & ~32'h08) | 32'h80 | (mstatus[7] ? 32'h08 : 32'h0);
         begin
            logic [31:0] tgt;
            tgt = mtvec;
            cap(6, 1'b1);
            for (int c = 0; c < 6; c++) begin
               exp = '0;
               if (sync || as) begin
                  exp[78] = (c <= 4);
                  if (c == 1) exp[77:33] = {1'b1, 12'h341, epc};
                  if (c == 2) exp[77:33] = {1'b1, 12'h342, cause};
                  if (c == 3) exp[77:33] = {1'b1, 12'h300, mst_trap};
                  if (c == 4) exp[32:0] = {1'b1, tgt};
               end else if (mr) begin
                  exp[78] = (c <= 2);
                  if (c == 1) exp[77:33] = {1'b1, 12'h300, mst_mret};
                  if (c == 2) exp[32:0] = {1'b1, mepc};
               end
               act = {h[c], we[c], wa[c], wd[c], ia[c], iad[c]};
               nchk++; if (act !== exp) begin
                  nerr++; $display("FAIL rand it%0d c%0d inst=%h: got %h expected %h", it, c, inst_i, act, exp);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_timer();
      test_mret();
      test_ecall_with_irq();
      test_stall();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
